vex_lane_pipe: RTL
==================

# vex_lane_pipe

Parametrised per-lane vector execution pipe: the next generation of the single-cycle lane pipe. It adds a configurable stage count, valid/ready backpressure with bubble squeezing, mask and vl tail handling, destination tags, flush, and two forwarding taps. One instance sits in each vector lane between operand read and the lane's register-file write port.

## Interface
- DATA_WIDTH, 32, element width in bits.
- MICROOP_WIDTH, 5, microop field width.
- VECTOR_LANES, 8, lane count; sets vl width.
- EX_STAGES, 3, pipeline depth; legal range 2..8.
- TAG_WIDTH, 5, destination tag width (register index).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- flush_i  in  1  discard all in-flight elements.
- valid_i  in  1  input element valid.
- ready_o  out  1  pipe can accept this cycle.
- mask_i  in  1  element mask bit; 1 = active.
- elem_idx_i  in  $clog2(32*VECTOR_LANES)+1  element index.
- vl_i  in  $clog2(32*VECTOR_LANES)+1  vector length.
- data_a_i, data_b_i, immediate_i  in  DATA_WIDTH  operands.
- microop_i  in  MICROOP_WIDTH  operation.
- fu_i  in  2  bit0 = use immediate_i as operand b; bit1 reserved.
- tag_i  in  TAG_WIDTH  destination tag.
- frw_a_en_o / frw_a_data_o / frw_a_tag_o  out  1/DATA_WIDTH/TAG_WIDTH  stage-1 tap.
- frw_b_en_o / frw_b_data_o / frw_b_tag_o  out  1/DATA_WIDTH/TAG_WIDTH  stage-2 tap.
- wr_en_o  out  1  output element valid.
- wr_ready_i  in  1  write port accepts.
- wr_mask_o  out  1  1 = commit data; 0 = completion only, no write.
- wr_data_o  out  DATA_WIDTH  result.
- wr_tag_o  out  TAG_WIDTH  destination tag.

## Operation
- Accept when valid_i & ready_o & ~flush_i.
- ALU evaluates on accept and writes the result into stage 1. Stages 2..EX_STAGES carry result, tag, active bit and valid bit.
- Operand b is immediate_i when fu_i[0], else data_b_i.
- Microops: 0 ADD, 1 SUB (a-b), 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 MIN (signed), 9 MINU, 10 MAX, 11 MAXU, 12 MOVE (result = b). All others produce 0.
- Shift amount is b[$clog2(DATA_WIDTH)-1:0]. Arithmetic wraps modulo 2^DATA_WIDTH.
- Active = mask_i & (elem_idx_i < vl_i), unsigned compare.
- Inactive elements still traverse the pipe with wr_en_o=1 and wr_mask_o=0. Their data is forced to 0. Forward taps ignore them.
- Stage s advances when stage s+1 is empty or advancing. The last stage advances when wr_ready_i is high. Bubbles collapse.
- ready_o = ~rst & (stage 1 empty | stage 1 advancing). It is combinational from wr_ready_i.
- frw_a_en_o = stage 1 valid & active. frw_b_en_o = stage 2 valid & active. Data and tag outputs are 0 when the matching enable is low.
- wr_data_o, wr_tag_o and wr_mask_o are 0 when wr_en_o is low.
- Flush clears every valid bit on the next edge, including an element being accepted in the same cycle. An element handed off with wr_en_o & wr_ready_i in the flush cycle counts as delivered.

## Timing
- Reset: all valid bits go to 0 on the first edge with rst high. All outputs are 0 during reset and after it, until the first accept. ready_o is 0 while rst is high and 1 in the first cycle after.
- Reset mid-operation drops all in-flight elements. No write is issued.
- Latency: an element accepted in cycle 0 shows wr_en_o in cycle EX_STAGES when there are no stalls. It shows on the stage-1 tap in cycle 1 and on the stage-2 tap in cycle 2.
- Throughput: 1 element/cycle while wr_ready_i stays high.
- Full pipe with wr_ready_i low: all EX_STAGES stages hold; ready_o=0; outputs stay stable.
- Full pipe with wr_ready_i rising: ready_o=1 in the same cycle. The output and the new input move in the same edge.
- The pipe holds at most EX_STAGES elements. wr_en_o and the output payload remain stable until wr_ready_i is seen high.

## Test plan
- EX_STAGES=3, wr_ready_i=1: ADD a=5, b=7 in cycle 0 -> wr_en_o=1, wr_data_o=12, wr_mask_o=1 in cycle 3. frw_a_en_o in cycle 1, frw_b_en_o in cycle 2, each with data 12.
- Immediate and signed ops: SRA a=0x80000000, fu_i=1, imm=4 -> 0xF8000000. MIN a=-1, b=1 -> 0xFFFFFFFF. MINU with the same operands -> 1. SUB 0-1 -> 0xFFFFFFFF.
- Tail and mask: vl_i=3, stream elem_idx 0..4 with mask 1,0,1,1,1 -> wr_mask_o sequence 1,0,1,0,0. Five wr_en_o pulses. Masked-off data is 0. Forward taps fire only for indices 0 and 2.
- Backpressure: stream 6 back-to-back elements with wr_ready_i held low -> ready_o drops after 3 accepts. Release wr_ready_i -> all 6 results arrive in order, none lost or duplicated.
- Flush: 3 elements in flight plus flush_i together with valid_i -> no further wr_en_o. ready_o=1 in the next cycle.
- Reset asserted mid-stream for 1 cycle -> all outputs 0 on the following cycle. The first new element returns after EX_STAGES cycles.

Source files
------------

// File: rtl/vex_lane_pipe.sv
// vex_lane_pipe: per-lane vector execution pipe with EX_STAGES collapsing
// stages, valid/ready backpressure, mask/vl tail handling, flush and two
// forwarding taps.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   flush_i                    drop every in-flight element
//   valid_i / ready_o          input handshake (ready_o is combinational from wr_ready_i)
//   mask_i, elem_idx_i, vl_i   element activity (active = mask & idx < vl)
//   data_a_i, data_b_i, immediate_i, microop_i, fu_i, tag_i   element payload
//   frw_a_* / frw_b_*          stage-1 / stage-2 forwarding taps (active elements only)
//   wr_en_o / wr_ready_i       output handshake
//   wr_mask_o, wr_data_o, wr_tag_o   result payload (zero when wr_en_o is low)
module vex_lane_pipe #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned MICROOP_WIDTH = 5,
  parameter int unsigned VECTOR_LANES  = 8,
  parameter int unsigned EX_STAGES     = 3,
  parameter int unsigned TAG_WIDTH     = 5
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush_i,
  input  logic                                valid_i,
  output logic                                ready_o,
  input  logic                                mask_i,
  input  logic [$clog2(32*VECTOR_LANES):0]    elem_idx_i,
  input  logic [$clog2(32*VECTOR_LANES):0]    vl_i,
  input  logic [DATA_WIDTH-1:0]               data_a_i,
  input  logic [DATA_WIDTH-1:0]               data_b_i,
  input  logic [DATA_WIDTH-1:0]               immediate_i,
  input  logic [MICROOP_WIDTH-1:0]            microop_i,
  input  logic [1:0]                          fu_i,
  input  logic [TAG_WIDTH-1:0]                tag_i,
  output logic                                frw_a_en_o,
  output logic [DATA_WIDTH-1:0]               frw_a_data_o,
  output logic [TAG_WIDTH-1:0]                frw_a_tag_o,
  output logic                                frw_b_en_o,
  output logic [DATA_WIDTH-1:0]               frw_b_data_o,
  output logic [TAG_WIDTH-1:0]                frw_b_tag_o,
  output logic                                wr_en_o,
  input  logic                                wr_ready_i,
  output logic                                wr_mask_o,
  output logic [DATA_WIDTH-1:0]               wr_data_o,
  output logic [TAG_WIDTH-1:0]                wr_tag_o
);

  localparam int unsigned SH_W = $clog2(DATA_WIDTH);
  localparam int unsigned LAST = EX_STAGES - 1;

  localparam logic [MICROOP_WIDTH-1:0] OP_ADD  = MICROOP_WIDTH'(0);
  localparam logic [MICROOP_WIDTH-1:0] OP_SUB  = MICROOP_WIDTH'(1);
  localparam logic [MICROOP_WIDTH-1:0] OP_AND  = MICROOP_WIDTH'(2);
  localparam logic [MICROOP_WIDTH-1:0] OP_OR   = MICROOP_WIDTH'(3);
  localparam logic [MICROOP_WIDTH-1:0] OP_XOR  = MICROOP_WIDTH'(4);
  localparam logic [MICROOP_WIDTH-1:0] OP_SLL  = MICROOP_WIDTH'(5);
  localparam logic [MICROOP_WIDTH-1:0] OP_SRL  = MICROOP_WIDTH'(6);
  localparam logic [MICROOP_WIDTH-1:0] OP_SRA  = MICROOP_WIDTH'(7);
  localparam logic [MICROOP_WIDTH-1:0] OP_MIN  = MICROOP_WIDTH'(8);
  localparam logic [MICROOP_WIDTH-1:0] OP_MINU = MICROOP_WIDTH'(9);
  localparam logic [MICROOP_WIDTH-1:0] OP_MAX  = MICROOP_WIDTH'(10);
  localparam logic [MICROOP_WIDTH-1:0] OP_MAXU = MICROOP_WIDTH'(11);
  localparam logic [MICROOP_WIDTH-1:0] OP_MOVE = MICROOP_WIDTH'(12);

  logic [EX_STAGES-1:0]  valid_q, valid_d;
  logic [EX_STAGES-1:0]  act_q, act_d;
  logic [DATA_WIDTH-1:0] data_q [EX_STAGES];
  logic [DATA_WIDTH-1:0] data_d [EX_STAGES];
  logic [TAG_WIDTH-1:0]  tag_q  [EX_STAGES];
  logic [TAG_WIDTH-1:0]  tag_d  [EX_STAGES];

  logic [EX_STAGES-1:0]  load_c;
  logic [DATA_WIDTH-1:0] opb_c, alu_c;
  logic [SH_W-1:0]       shamt_c;
  logic                  active_c, accept_c;
  logic                  unused_fu;

  assign unused_fu = fu_i[1];

  // Element ALU, evaluated in the accept cycle.
  always_comb begin
    opb_c   = fu_i[0] ? immediate_i : data_b_i;
    shamt_c = opb_c[SH_W-1:0];
    alu_c   = '0;
    case (microop_i)
      OP_ADD:  alu_c = data_a_i + opb_c;
      OP_SUB:  alu_c = data_a_i - opb_c;
      OP_AND:  alu_c = data_a_i & opb_c;
      OP_OR:   alu_c = data_a_i | opb_c;
      OP_XOR:  alu_c = data_a_i ^ opb_c;
      OP_SLL:  alu_c = data_a_i << shamt_c;
      OP_SRL:  alu_c = data_a_i >> shamt_c;
      OP_SRA:  alu_c = DATA_WIDTH'($signed(data_a_i) >>> shamt_c);
      OP_MIN:  alu_c = ($signed(data_a_i) < $signed(opb_c)) ? data_a_i : opb_c;
      OP_MINU: alu_c = (data_a_i < opb_c) ? data_a_i : opb_c;
      OP_MAX:  alu_c = ($signed(data_a_i) > $signed(opb_c)) ? data_a_i : opb_c;
      OP_MAXU: alu_c = (data_a_i > opb_c) ? data_a_i : opb_c;
      OP_MOVE: alu_c = opb_c;
      default: alu_c = '0;
    endcase
  end

  // A stage may load when it is empty or when everything downstream drains;
  // this chain is what squeezes bubbles out of a stalled pipe.
  always_comb begin
    logic chain;
    chain  = wr_ready_i;
    load_c = '0;
    for (int s = int'(LAST); s >= 0; s--) begin
      chain     = ~valid_q[s] | chain;
      load_c[s] = chain;
    end
  end

  assign active_c = mask_i & (elem_idx_i < vl_i);
  assign ready_o  = ~rst & load_c[0];
  assign accept_c = valid_i & ready_o & ~flush_i;

  // Next-state for all stages; flush wins over any load.
  always_comb begin
    valid_d = valid_q;
    act_d   = act_q;
    data_d  = data_q;
    tag_d   = tag_q;
    if (load_c[0]) begin
      valid_d[0] = accept_c;
      act_d[0]   = active_c;
      data_d[0]  = active_c ? alu_c : '0;
      tag_d[0]   = tag_i;
    end
    for (int s = 1; s < int'(EX_STAGES); s++) begin
      if (load_c[s]) begin
        valid_d[s] = valid_q[s-1];
        act_d[s]   = act_q[s-1];
        data_d[s]  = data_q[s-1];
        tag_d[s]   = tag_q[s-1];
      end
    end
    if (flush_i) valid_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      act_q   <= '0;
      for (int s = 0; s < int'(EX_STAGES); s++) begin
        data_q[s] <= '0;
        tag_q[s]  <= '0;
      end
    end else begin
      valid_q <= valid_d;
      act_q   <= act_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
    end
  end

  // Output views; everything reads as zero while reset is held.
  assign frw_a_en_o   = ~rst & valid_q[0] & act_q[0];
  assign frw_a_data_o = frw_a_en_o ? data_q[0] : '0;
  assign frw_a_tag_o  = frw_a_en_o ? tag_q[0]  : '0;
  assign frw_b_en_o   = ~rst & valid_q[1] & act_q[1];
  assign frw_b_data_o = frw_b_en_o ? data_q[1] : '0;
  assign frw_b_tag_o  = frw_b_en_o ? tag_q[1]  : '0;

  assign wr_en_o      = ~rst & valid_q[LAST];
  assign wr_mask_o    = wr_en_o & act_q[LAST];
  assign wr_data_o    = wr_en_o ? data_q[LAST] : '0;
  assign wr_tag_o     = wr_en_o ? tag_q[LAST]  : '0;

endmodule
